rx_filtered_samples_reader: RTL and testbench

- Read-side engine for the 16x512 filtered-sample block RAM in the rx chain.
- On a start command, fetches a window of consecutive samples beginning at a given address, wrapping modulo 512.
- Streams the samples to a downstream consumer (correlator/detector) over a valid/ready interface.
- Absorbs the RAM's 1-cycle registered read latency with an internal 2-entry skid buffer, so full throughput is kept under backpressure.

---
 rtl/rx_filtered_samples_reader.sv | 111 +++++++++++
 tb/tb_rx_filtered_samples_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rx_filtered_samples_reader.sv
// rx_filtered_samples_reader: streams a modulo-512 window of the filtered-sample RAM
// to a valid/ready consumer, hiding the RAM read latency behind a 2-entry skid buffer.
module rx_filtered_samples_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rx_rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_dob,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              sample_last,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d, len_sat;
    logic              in_flight_q, in_flight_d, fl_last_q, fl_last_d;
    logic [DATA_W:0]   buf_q [2];
    logic [DATA_W:0]   buf_d [2];
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              issue, push, pop, abort_ok;

    assign len_sat  = (length > MAX_LEN) ? MAX_LEN : length;
    assign push     = in_flight_q;
    assign pop      = sample_valid & sample_ready;
    assign abort_ok = abort & (state_q == READ || state_q == DRAIN);
    // Issue only while buffered + in-flight after this cycle's pop stays below 2.
    assign issue    = (state_q == READ) &&
                      (({1'b0, cnt_q} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop}));

    assign ram_enb      = issue;
    assign ram_addrb    = addr_q;
    assign sample_valid = cnt_q != 2'd0;
    assign sample_out   = buf_q[rd_q][DATA_W-1:0];
    assign sample_last  = sample_valid & buf_q[rd_q][DATA_W];
    assign busy         = state_q != IDLE;
    assign done         = state_q == FIN;

    always_comb begin
        state_d     = state_q;
        addr_d      = issue ? addr_q + 1'b1 : addr_q;
        rem_d       = issue ? rem_q - 1'b1 : rem_q;
        buf_d       = buf_q;
        rd_d        = rd_q ^ pop;
        wr_d        = wr_q ^ push;
        cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
        in_flight_d = issue;
        fl_last_d   = issue && rem_q == ONE;
        if (push)
            buf_d[wr_q] = {fl_last_q, ram_dob};
        case (state_q)
            // An empty window passes through DRAIN so done lands two cycles after start.
            IDLE: if (start) begin
                addr_d  = start_addr;
                rem_d   = len_sat;
                state_d = (len_sat == '0) ? DRAIN : READ;
            end
            READ:    if (issue && rem_q == ONE) state_d = DRAIN;
            DRAIN:   if (cnt_d == 2'd0) state_d = FIN;
            default: state_d = IDLE;
        endcase
        if (abort_ok) begin
            state_d     = IDLE;
            cnt_d       = 2'd0;
            rd_d        = 1'b0;
            wr_d        = 1'b0;
            in_flight_d = 1'b0;
            fl_last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            in_flight_q <= 1'b0;
            fl_last_q   <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            in_flight_q <= in_flight_d;
            fl_last_q   <= fl_last_d;
            buf_q       <= buf_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rx_filtered_samples_reader.sv
// tb_rx_filtered_samples_reader: scoreboard bench with a registered-read RAM model,
// randomised backpressure, abort, start-while-busy and asynchronous reset.
module tb_rx_filtered_samples_reader;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0, rx_rst_n = 1'b0, start = 1'b0, abort = 1'b0, sample_ready = 1'b0;
    logic [AW-1:0] start_addr = '0, ram_addrb;
    logic [AW:0]   length = '0;
    logic [DW-1:0] ram_dob, sample_out;
    logic          ram_enb, sample_valid, sample_last, busy, done;

    rx_filtered_samples_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rx_rst_n(rx_rst_n), .start(start), .start_addr(start_addr),
        .length(length), .abort(abort), .ram_enb(ram_enb), .ram_addrb(ram_addrb),
        .ram_dob(ram_dob), .sample_out(sample_out), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_last(sample_last), .busy(busy), .done(done)
    );

    logic [DW-1:0] mem [512];
    logic [DW:0]   exp_q [$];
    int checks = 0, errors = 0, cyc = 0, rdy_mode = 0;
    int outst = 0, done_cnt = 0, pops = 0, last_cnt = 0;
    int first_valid = -1, first_enb = -1, done_c = -1, last_c = -1;
    logic          prev_stall = 1'b0, pop;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (ram_enb) ram_dob <= mem[ram_addrb];

    // Mode 0: always ready; 1: random 50%; 2: random with a 5-cycle stall every 24 cycles.
    always begin
        @(posedge clk);
        #1;
        sample_ready = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 2 && cyc % 24 < 5) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rx_rst_n) begin
            pop = sample_valid && sample_ready;
            if (prev_stall) begin
                chk("hold_valid", 32'(sample_valid), 1);
                chk("hold_data", 32'(sample_out), 32'(prev_data));
            end
            if (sample_valid && first_valid < 0) first_valid = cyc;
            if (ram_enb && first_enb < 0) first_enb = cyc;
            if (done) begin done_cnt++; done_c = cyc; end
            if (pop) begin
                pops++;
                if (sample_last) begin last_cnt++; last_c = cyc; end
                if (exp_q.size() == 0) chk("sb_extra", 1, 0);
                else chk("sample", 32'({sample_last, sample_out}), 32'(exp_q.pop_front()));
            end
            outst = outst + int'(ram_enb) - int'(pop);
            if (ram_enb) chk("outst_le2", 32'(outst <= 2), 1);
            prev_stall = sample_valid && !sample_ready && !abort;
            prev_data  = sample_out;
            if (abort) outst = 0;
        end else begin
            outst = 0;
            prev_stall = 1'b0;
        end
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic window(input int a, input int len, input int mode, input bit timing, input int dup);
        int n, sc, p0, d0;
        n = (len > 512) ? 512 : len;
        rdy_mode = mode;
        first_valid = -1; first_enb = -1; done_c = -1; last_c = -1; last_cnt = 0;
        p0 = pops; d0 = done_cnt;
        for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, mem[(a + i) % 512]});
        start = 1'b1; start_addr = AW'(a); length = (AW + 1)'(len);
        @(posedge clk); #1;
        sc = cyc; start = 1'b0;
        @(negedge clk);
        chk("busy_on", 32'(busy), 1);
        if (dup > 0) begin
            repeat (dup) @(posedge clk);
            #1 start = 1'b1; start_addr = 9'd300; length = 10'd5;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
        chk("done_cnt", 32'(done_cnt - d0), 1);
        chk("sb_left", 32'(exp_q.size()), 0);
        chk("n_samples", 32'(pops - p0), 32'(n));
        chk("n_last", 32'(last_cnt), (n > 0) ? 1 : 0);
        if (n > 0) chk("last_to_done", 32'(done_c - last_c), 1);
        if (timing && n > 0) begin
            chk("first_enb", 32'(first_enb), 32'(sc));
            chk("first_valid", 32'(first_valid), 32'(sc + 2));
        end
        if (timing && n == 0) begin
            chk("zero_done", 32'(done_c), 32'(sc + 1));
            chk("zero_novalid", 32'(first_valid), 32'(-1));
        end
        @(negedge clk);
        chk("busy_off", 32'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 512; i++) mem[i] = DW'(i + 100);
        #12;
        chk("rst_outs", 32'({ram_enb, busy, done, sample_valid, sample_last}), 0);
        chk("rst_data", 32'(sample_out), 0);
        @(posedge clk); #1 rx_rst_n = 1'b1;
        @(posedge clk); #1;
        window(10, 8, 0, 1, 0);
        window(508, 8, 0, 1, 0);
        window(400, 32, 2, 0, 0);
        window(77, 32, 1, 0, 0);
        window(5, 0, 0, 1, 0);
        window(100, 600, 0, 0, 0);
        window(20, 32, 1, 0, 4);
        // Abort mid-READ under random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) exp_q.push_back({i == 39, mem[(50 + i) % 512]});
        start = 1'b1; start_addr = 9'd50; length = 10'd40;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        d0 = done_cnt;
        exp_q.delete();
        rdy_mode = 0;
        @(negedge clk);
        chk("abort_outs", 32'({sample_valid, busy, ram_enb}), 0);
        repeat (10) @(posedge clk);
        chk("abort_nodone", 32'(done_cnt - d0), 0);
        #1;
        window(60, 10, 0, 1, 0);
        // Asynchronous reset in the middle of a window.
        for (int i = 0; i < 20; i++) exp_q.push_back({i == 19, mem[200 + i]});
        start = 1'b1; start_addr = 9'd200; length = 10'd20;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rx_rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'({ram_enb, busy, done, sample_valid, sample_last}), 0);
        chk("rst_mid_data", 32'(sample_out), 0);
        chk("rst_mid_addr", 32'(ram_addrb), 0);
        exp_q.delete();
        @(posedge clk); #1 rx_rst_n = 1'b1;
        @(posedge clk); #1;
        window(300, 12, 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
